// File: rtl/vga_slideshow_gen.sv
// VGA timing generator with framed-image slideshow fetched from an external ROM.
// Optional build macro VGA_BORDER_EN draws a 1-px red ring around the image window.
module vga_slideshow_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter int unsigned SYNC_POS = 1,
    parameter int unsigned IMG_W    = 150,
    parameter int unsigned IMG_H    = 100,
    parameter int unsigned IMG_X    = 325,
    parameter int unsigned IMG_Y    = 250,
    parameter int unsigned NUM_IMGS = 4,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEB_CYC  = 400000,
    parameter logic [7:0]  BG_RGB   = 8'hFF,
    localparam int unsigned IDX_W   = (NUM_IMGS > 1) ? $clog2(NUM_IMGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              next_img,
    input  logic              prev_img,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_data,
    output logic [2:0]        red,
    output logic [2:0]        green,
    output logic [1:0]        blue,
    output logic              hsync,
    output logic              vsync,
    output logic [IDX_W-1:0]  img_idx,
    output logic              frame_strt
);

    localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW     = $clog2(H_TOT);
    localparam int unsigned VW     = $clog2(V_TOT);
    localparam int unsigned IMG_SZ = IMG_W * IMG_H;
    localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);
    localparam logic        SYNC_ACT = (SYNC_POS != 0);

    // Stage 0: raster counters
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == HW'(H_TOT - 1)) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VW'(V_TOT - 1)) ? '0 : vcnt_q + VW'(1);
        end
    end

    logic sof0, win0, hs0, vs0;

    always_comb begin
        sof0 = (hcnt_q == '0) && (vcnt_q == '0);
        win0 = (hcnt_q >= HW'(IMG_X)) && (hcnt_q < HW'(IMG_X + IMG_W)) &&
               (vcnt_q >= VW'(IMG_Y)) && (vcnt_q < VW'(IMG_Y + IMG_H));
        hs0  = (hcnt_q >= HW'(H_ACTIVE + H_FP)) && (hcnt_q < HW'(H_ACTIVE + H_FP + H_SYNC));
        vs0  = (vcnt_q >= VW'(V_ACTIVE + V_FP)) && (vcnt_q < VW'(V_ACTIVE + V_FP + V_SYNC));
    end

`ifdef VGA_BORDER_EN
    localparam logic [7:0] BORDER_RGB = 8'hE0;
    logic brd0, brd1_q;
    logic h_span, v_span, h_edge, v_edge;

    // Ring one pixel outside the window on every side, corners included
    always_comb begin
        h_span = (hcnt_q >= HW'(IMG_X - 1)) && (hcnt_q <= HW'(IMG_X + IMG_W));
        v_span = (vcnt_q >= VW'(IMG_Y - 1)) && (vcnt_q <= VW'(IMG_Y + IMG_H));
        h_edge = (hcnt_q == HW'(IMG_X - 1)) || (hcnt_q == HW'(IMG_X + IMG_W));
        v_edge = (vcnt_q == VW'(IMG_Y - 1)) || (vcnt_q == VW'(IMG_Y + IMG_H));
        brd0   = (h_span && v_edge) || (v_span && h_edge);
    end
`endif

    // ROM addressing: running offset restarts at frame start, saturates at the image end
    logic [IDX_W-1:0]  img_idx_q, img_idx_d;
    logic [ADDR_W-1:0] off_q, off_d, off_cur, base, addr_q, addr_d;

    always_comb begin
        off_cur = sof0 ? '0 : off_q;
        off_d   = off_cur;
        if (win0 && (off_cur != ADDR_W'(IMG_SZ - 1))) begin
            off_d = off_cur + ADDR_W'(1);
        end
        base   = ADDR_W'(img_idx_q) * ADDR_W'(IMG_SZ);
        addr_d = base + off_cur;
    end

    // Button synchroniser + debounce; bit 0 = next, bit 1 = prev
    logic [1:0]       btn_meta_q, btn_sync_q, deb_q, deb_d, rise;
    logic [DEB_W-1:0] deb_cnt_q [2];
    logic [DEB_W-1:0] deb_cnt_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = '0;
            if (btn_sync_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEB_CYC - 1)) begin
                    deb_d[i] = btn_sync_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
        rise = deb_d & ~deb_q;
    end

    // Pending requests: conflicting ones cancel, otherwise applied at frame start
    logic pend_next_q, pend_next_d, pend_prev_q, pend_prev_d;
    logic pn, pp;

    always_comb begin
        pn          = pend_next_q | rise[0];
        pp          = pend_prev_q | rise[1];
        img_idx_d   = img_idx_q;
        pend_next_d = pn;
        pend_prev_d = pp;
        if (pn && pp) begin
            pend_next_d = 1'b0;
            pend_prev_d = 1'b0;
        end else if (sof0) begin
            if (pn) begin
                img_idx_d = (img_idx_q == IDX_W'(NUM_IMGS - 1)) ? '0 : img_idx_q + IDX_W'(1);
            end else if (pp) begin
                img_idx_d = (img_idx_q == '0) ? IDX_W'(NUM_IMGS - 1) : img_idx_q - IDX_W'(1);
            end
            pend_next_d = 1'b0;
            pend_prev_d = 1'b0;
        end
    end

    // Stage 2: pixel colour and sync polarity
    logic       win1_q, hs1_q, vs1_q, sof1_q;
    logic [7:0] rgb_q, rgb_d;
    logic       hsync_q, vsync_q, frame_strt_q;

    always_comb begin
        rgb_d = BG_RGB;
        if (win1_q) begin
            rgb_d = {{3{rom_data[2]}}, {3{rom_data[1]}}, {2{rom_data[0]}}};
`ifdef VGA_BORDER_EN
        end else if (brd1_q) begin
            rgb_d = BORDER_RGB;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            off_q        <= '0;
            addr_q       <= '0;
            img_idx_q    <= '0;
            btn_meta_q   <= '0;
            btn_sync_q   <= '0;
            deb_q        <= '0;
            for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
            pend_next_q  <= 1'b0;
            pend_prev_q  <= 1'b0;
            win1_q       <= 1'b0;
            hs1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            sof1_q       <= 1'b0;
`ifdef VGA_BORDER_EN
            brd1_q       <= 1'b0;
`endif
            rgb_q        <= BG_RGB;
            hsync_q      <= ~SYNC_ACT;
            vsync_q      <= ~SYNC_ACT;
            frame_strt_q <= 1'b0;
        end else begin
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            off_q        <= off_d;
            addr_q       <= addr_d;
            img_idx_q    <= img_idx_d;
            btn_meta_q   <= {prev_img, next_img};
            btn_sync_q   <= btn_meta_q;
            deb_q        <= deb_d;
            for (int i = 0; i < 2; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            pend_next_q  <= pend_next_d;
            pend_prev_q  <= pend_prev_d;
            win1_q       <= win0;
            hs1_q        <= hs0;
            vs1_q        <= vs0;
            sof1_q       <= sof0;
`ifdef VGA_BORDER_EN
            brd1_q       <= brd0;
`endif
            rgb_q        <= rgb_d;
            hsync_q      <= hs1_q ? SYNC_ACT : ~SYNC_ACT;
            vsync_q      <= vs1_q ? SYNC_ACT : ~SYNC_ACT;
            frame_strt_q <= sof1_q;
        end
    end

    assign rom_addr   = addr_q;
    assign red        = rgb_q[7:5];
    assign green      = rgb_q[4:2];
    assign blue       = rgb_q[1:0];
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign img_idx    = img_idx_q;
    assign frame_strt = frame_strt_q;

endmodule
